// File: rtl/traffic_ctrl.sv
// traffic_ctrl: two-approach intersection controller with tick prescaler, request-driven early green end and all-red clearance.
// Optional TRAFFIC_FLASH_EN adds flash_i for a flashing-yellow mode.
module traffic_ctrl #(
  parameter int CLK_DIV     = 50000000,
  parameter int CNT_W       = 8,
  parameter int T_GREEN     = 10,
  parameter int T_MIN_GREEN = 4,
  parameter int T_YELLOW    = 3,
  parameter int T_ALLRED    = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic       req1_i,
  input  logic       req2_i,
`ifdef TRAFFIC_FLASH_EN
  input  logic       flash_i,
`endif
  output logic       red1_o,
  output logic       yellow1_o,
  output logic       green1_o,
  output logic       red2_o,
  output logic       yellow2_o,
  output logic       green2_o,
  output logic [2:0] phase_o,
  output logic       tick_o
);
  localparam int PW = $clog2(CLK_DIV);
  typedef enum logic [2:0] {G1 = 3'd0, Y1 = 3'd1, R1 = 3'd2, G2 = 3'd3, Y2 = 3'd4, R2 = 3'd5} phase_t;
  phase_t state, nxt, cur;
  logic [PW-1:0] pre;
  logic [CNT_W-1:0] timer, timer_nxt;
  logic pend1, pend2, done, lg, early, flash, rel, blink;
`ifdef TRAFFIC_FLASH_EN
  logic flash_q;
  assign flash = flash_i;
  assign rel = flash_q && !flash_i;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      flash_q <= 1'b0;
      blink <= 1'b1;
    end else begin
      flash_q <= flash_i;
      blink <= !flash_i ? 1'b1 : tick_o ? ~blink : blink;
    end
  end
`else
  assign flash = 1'b0;
  assign rel = 1'b0;
  assign blink = 1'b0;
`endif
  assign tick_o = en_i && pre == PW'(CLK_DIV - 1);
  // On flash release the intersection shows all-red straight away.
  assign cur = rel ? R2 : state;
  always_comb begin
    lg = timer == CNT_W'(T_GREEN - 1);
    early = timer >= CNT_W'(T_MIN_GREEN - 1);
    done = tick_o && (state == G1 ? lg || (pend2 && early) :
                      state == G2 ? lg || (pend1 && early) :
                      (state == Y1 || state == Y2) ? timer == CNT_W'(T_YELLOW - 1) :
                      timer == CNT_W'(T_ALLRED - 1));
    nxt = flash ? state : rel ? R2 : state > R2 ? R2 : !done ? state :
          state == R2 ? G1 : phase_t'(state + 3'd1);
    timer_nxt = flash ? timer : (rel || nxt != state) ? '0 : tick_o ? timer + 1'b1 : timer;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pre <= '0;
      timer <= '0;
      pend1 <= 1'b0;
      pend2 <= 1'b0;
      state <= G1;
    end else begin
      pre <= !en_i ? pre : tick_o ? '0 : pre + 1'b1;
      timer <= timer_nxt;
      state <= nxt;
      pend1 <= nxt == G1 ? 1'b0 : pend1 | (req1_i && state != G1);
      pend2 <= nxt == G2 ? 1'b0 : pend2 | (req2_i && state != G2);
    end
  end
  always_comb begin
    green1_o = !flash && cur == G1;
    yellow1_o = flash ? blink : cur == Y1;
    red1_o = !flash && cur != G1 && cur != Y1;
    green2_o = !flash && cur == G2;
    yellow2_o = flash ? blink : cur == Y2;
    red2_o = !flash && cur != G2 && cur != Y2;
    phase_o = flash ? 3'd7 : cur;
  end
endmodule
